// File: rtl/swcap_pkg.sv
// Shared constants for the slide-switch capture responder:
// register addresses, controller states and edge-mode encodings.
package swcap_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_TSTAMP = 3'd4;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/swcap_debounce.sv
// One switch bit: 2-FF synchroniser, debounce counter and accepted level.
// change pulses combinationally on the cycle stable takes the new level.
module swcap_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic raw,
    output logic sync,
    output logic stable,
    output logic change
);

    logic             meta;
    logic [CNT_W-1:0] cnt;
    logic             differ;

    assign differ = sync != stable;
    assign change = run && differ
                 && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            // Before RUN the accepted level simply tracks the pins.
            if (!run || change) begin
                stable <= sync;
                cnt    <= '0;
            end else if (differ) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_capture_if.sv
// Avalon-MM slide-switch reader with sticky edge flags and maskable irq.
// Define SWCAP_TIMESTAMP_EN to add the edge timestamp register.
module switch_capture_if
    import swcap_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    state_t           state;
    logic [CNT_W-1:0] init_cnt;
    logic             run;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] change;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [31:0]      ts_rd;
    logic [31:0]      rd_mux;

    assign run = state == RUN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        swcap_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .run   (run),
            .raw   (sw_in[i]),
            .sync  (sync[i]),
            .stable(stable[i]),
            .change(change[i])
        );
    end

    always_comb begin
        edges = change;
        if (EDGE_MODE == EDGE_RISE) begin
            edges = change & sync;
        end else if (EDGE_MODE == EDGE_FALL) begin
            edges = change & ~sync;
        end
    end

    assign w1c = (avs_write && avs_address == ADDR_EDGE)
               ? avs_writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == CNT_W'(DEBOUNCE_CYCLES + 1)) begin
                        state    <= RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // A new edge in the same cycle as its W1C leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~w1c) | edges;
            irq      <= |(edge_cap & irq_mask);
            if (avs_write && avs_address == ADDR_MASK) begin
                irq_mask <= avs_writedata[WIDTH-1:0];
            end
        end
    end

`ifdef SWCAP_TIMESTAMP_EN
    logic [31:0] tcount;
    logic [31:0] tstamp;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcount <= '0;
            tstamp <= '0;
        end else begin
            tcount <= tcount + 32'd1;
            if (|edges) begin
                tstamp <= tcount;
            end
        end
    end

    assign ts_rd = tstamp;
`else
    assign ts_rd = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA:   rd_mux = 32'(stable);
            ADDR_MASK:   rd_mux = 32'(irq_mask);
            ADDR_EDGE:   rd_mux = 32'(edge_cap);
            ADDR_STATUS: rd_mux = {30'd0, irq, run};
            ADDR_TSTAMP: rd_mux = ts_rd;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_switch_capture_if.sv
// Bench for switch_capture_if: cycle model of the main instance plus
// literal read checks, and a falling-edge-only second instance.
module tb_switch_capture_if;

    localparam int W = 10;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw_in = '0;
    logic [2:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    logic        reset1 = 1'b1;
    logic [9:0]  sw1 = '0;
    logic [2:0]  addr1 = '0;
    logic        rd1 = 1'b0;
    logic [31:0] rdata1;
    logic        irq1;

    int vec = 0;
    int miss = 0;
    bit chk = 0;

    always #5 clk = ~clk;

    switch_capture_if #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .avs_address(addr), .avs_read(rd), .avs_write(wr),
        .avs_writedata(wdata), .avs_readdata(rdata), .irq(irq)
    );

    switch_capture_if #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset(reset1), .sw_in(sw1),
        .avs_address(addr1), .avs_read(rd1), .avs_write(1'b0),
        .avs_writedata(32'd0), .avs_readdata(rdata1), .irq(irq1)
    );

    // Model: a bit is accepted after disagreeing with the accepted
    // level for D consecutive cycles at the synchroniser output.
    bit [9:0]  m_s1, m_sync, m_stable, m_edge, m_mask;
    int        m_len[10];
    bit        m_run;
    int        m_icnt;
    bit        m_irq;
    bit [31:0] m_rd, m_tcnt, m_ts;

    always @(posedge clk) begin
        bit [9:0] ev;
        bit [9:0] clr;
        ev = '0;
        if (reset) begin
            m_s1 = 0; m_sync = 0; m_stable = 0; m_edge = 0; m_mask = 0;
            m_run = 0; m_icnt = 0; m_irq = 0; m_rd = 0;
            m_tcnt = 0; m_ts = 0;
            for (int i = 0; i < 10; i++) m_len[i] = 0;
        end else begin
            if (rd) begin
                case (addr)
                    3'd0: m_rd = {22'd0, m_stable};
                    3'd1: m_rd = {22'd0, m_mask};
                    3'd2: m_rd = {22'd0, m_edge};
                    3'd3: m_rd = {30'd0, m_irq, m_run};
                    3'd4: m_rd = m_ts;
                    default: m_rd = 0;
                endcase
            end
            m_irq = |(m_edge & m_mask);
            if (!m_run) begin
                m_stable = m_sync;
                if (m_icnt == D + 1) m_run = 1;
                else m_icnt++;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (m_sync[i] != m_stable[i]) begin
                        m_len[i]++;
                        if (m_len[i] == D) begin
                            m_stable[i] = m_sync[i];
                            ev[i] = 1;
                            m_len[i] = 0;
                        end
                    end else begin
                        m_len[i] = 0;
                    end
                end
            end
            clr = (wr && addr == 3'd2) ? wdata[9:0] : 10'd0;
            m_edge = (m_edge & ~clr) | ev;
            if (wr && addr == 3'd1) m_mask = wdata[9:0];
`ifdef SWCAP_TIMESTAMP_EN
            if (|ev) m_ts = m_tcnt;
            m_tcnt++;
`endif
            m_sync = m_s1;
            m_s1 = sw_in;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vec++;
            if (rdata !== m_rd || irq !== m_irq) begin
                miss++;
                $display("FAIL cycle t=%0t readdata=%h irq=%b want %h/%b",
                         $time, rdata, irq, m_rd, m_irq);
            end
        end
    end

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp,
                          input string nm);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        vec++;
        if (rdata !== exp) begin
            miss++;
            $display("FAIL %s got %h want %h", nm, rdata, exp);
        end
    endtask

    task automatic rd1_chk(input logic [2:0] a, input logic [31:0] exp,
                           input string nm);
        @(negedge clk);
        addr1 = a; rd1 = 1'b1;
        @(negedge clk);
        rd1 = 1'b0;
        vec++;
        if (rdata1 !== exp) begin
            miss++;
            $display("FAIL %s got %h want %h", nm, rdata1, exp);
        end
    endtask

    initial begin
        sw_in = 10'h3FF;
        @(posedge clk);
        chk = 1;
        waitc(3);
        reset = 0;
        waitc(10);
        rd_chk(3'd0, 32'h3FF, "init_data");
        rd_chk(3'd2, 32'h0, "init_edge");
        rd_chk(3'd3, 32'h1, "init_status");

        @(negedge clk);
        reset = 1; sw_in = 10'h000;
        waitc(3);
        reset = 0;
        waitc(10);
        rd_chk(3'd0, 32'h0, "reinit_data");

        @(negedge clk);
        sw_in[0] = 1'b1;
        waitc(3);
        sw_in[0] = 1'b0;
        waitc(10);
        rd_chk(3'd0, 32'h0, "glitch_data");
        rd_chk(3'd2, 32'h0, "glitch_edge");

        wr_reg(3'd1, 32'h1);
        rd_chk(3'd1, 32'h1, "mask_rd");
        @(negedge clk);
        sw_in[0] = 1'b1;
        waitc(10);
        rd_chk(3'd0, 32'h1, "hold_data");
        rd_chk(3'd2, 32'h1, "hold_edge");
        rd_chk(3'd3, 32'h3, "irq_status");
        wr_reg(3'd2, 32'h2);
        rd_chk(3'd2, 32'h1, "w1c_other");
        wr_reg(3'd2, 32'h1);
        rd_chk(3'd2, 32'h0, "w1c_bit0");
        waitc(2);
        rd_chk(3'd3, 32'h1, "irq_clear");

        @(negedge clk);
        sw_in[3] = 1'b1;
        waitc(4);
        wr_reg(3'd2, 32'h8);
        waitc(2);
        rd_chk(3'd2, 32'h8, "edge_wins");
        rd_chk(3'd0, 32'h9, "data_b3");

        wr_reg(3'd2, 32'h3FF);
        @(negedge clk);
        sw_in = 10'h0F0;
        waitc(10);
        rd_chk(3'd0, 32'h0F0, "multi_data");
        rd_chk(3'd2, 32'h0F9, "multi_edge");
`ifdef SWCAP_TIMESTAMP_EN
        rd_chk(3'd4, m_ts, "tstamp");
`else
        rd_chk(3'd4, 32'h0, "tstamp_off");
`endif
        wr_reg(3'd0, 32'hFFFF_FFFF);
        rd_chk(3'd0, 32'h0F0, "ro_data");
        wr_reg(3'd5, 32'hFFFF_FFFF);
        rd_chk(3'd5, 32'h0, "addr5");
        wr_reg(3'd1, 32'hFFFF_FFFF);
        rd_chk(3'd1, 32'h3FF, "mask_width");

        @(negedge clk);
        sw_in[9] = 1'b1;
        waitc(2);
        reset = 1;
        waitc(2);
        reset = 0;
        waitc(10);
        rd_chk(3'd0, 32'h2F0, "midreset_data");
        rd_chk(3'd2, 32'h0, "midreset_edge");
        rd_chk(3'd1, 32'h0, "midreset_mask");

        @(negedge clk);
        reset1 = 0;
        waitc(12);
        sw1[5] = 1'b1;
        waitc(12);
        rd1_chk(3'd0, 32'h020, "fall_data_hi");
        rd1_chk(3'd2, 32'h0, "fall_no_rise");
        sw1[5] = 1'b0;
        waitc(12);
        rd1_chk(3'd2, 32'h020, "fall_edge");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
